mem_port_sched: RTL and testbench

Sequencer and arbiter for the single shared memory port of the multicycle core. The instruction-fetch stage and the load/store stage each raise a request. The block grants one at a time and drives the memory port with a fixed read latency. It returns a one-cycle acknowledge with read data to the winner. It sits between the controller-driven fetch/load-store logic and the block-RAM wrapper.

---
 rtl/mem_port_sched.sv | 120 ++++++++++++
 tb/tb_mem_port_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_sched.sv
// rtl/mem_port_sched.sv - round-robin sequencer for the shared fetch/load-store memory port
module mem_port_sched #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t            state_q;
  logic              sel_d_q;    // granted channel: 1 = data, 0 = fetch
  logic              last_d_q;   // last grant went to data
  logic              we_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              if_ack_q;
  logic              d_ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              pick_d;

  // Arbitration: a lone requester wins; on a tie, whoever was not granted last wins.
  always_comb begin
    pick_d = d_req && (!if_req || !last_d_q);
  end

  // Transaction FSM: grant in IDLE, strobe in ISSUE, count latency in WAIT, pulse ack in ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_d_q    <= 1'b0;
      last_d_q   <= 1'b0;
      we_q       <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      cnt_q      <= '0;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_req || d_req) begin
            sel_d_q  <= pick_d;
            last_d_q <= pick_d;
            we_q     <= pick_d && d_we;
            addr_q   <= pick_d ? d_addr : if_addr;
            if (pick_d) wdata_q <= d_wdata;
            mem_en_q <= 1'b1;
            mem_we_q <= pick_d && d_we;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= CNT_W'(MEM_LAT);
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            // Stores keep the same timing but never disturb the read-data registers.
            if (!we_q) begin
              if (sel_d_q) d_rdata_q  <= mem_rdata;
              else         if_rdata_q <= mem_rdata;
            end
            if_ack_q <= !sel_d_q;
            d_ack_q  <= sel_d_q;
            state_q  <= ACK;
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_sched.sv
// tb/tb_mem_port_sched.sv - scoreboard bench for mem_port_sched at MEM_LAT 2, 1 and 7
module tb_mem_port_sched;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int L0 = 2;
  localparam int L1 = 1;
  localparam int L7 = 7;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, if_req1 = 1'b0, if_req7 = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          d_req = 1'b0, d_we = 1'b0, no_req = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;

  logic          if_ack0, d_ack0, mem_en0, mem_we0, busy0;
  logic          if_ack1, d_ack1, mem_en1, mem_we1, busy1;
  logic          if_ack7, d_ack7, mem_en7, mem_we7, busy7;
  logic [DW-1:0] if_rdata0, d_rdata0, mem_wdata0, mem_rdata0;
  logic [DW-1:0] if_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
  logic [DW-1:0] if_rdata7, d_rdata7, mem_wdata7, mem_rdata7;
  logic [AW-1:0] mem_addr0, mem_addr1, mem_addr7;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q0[$], q1[$], q7[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_sched #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L0)) u0 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack0), .if_rdata(if_rdata0),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack0), .d_rdata(d_rdata0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .busy(busy0));

  mem_port_sched #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L1)) u1 (
    .clk(clk), .rst(rst), .if_req(if_req1), .if_addr(if_addr), .if_ack(if_ack1), .if_rdata(if_rdata1),
    .d_req(no_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1));

  mem_port_sched #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L7)) u7 (
    .clk(clk), .rst(rst), .if_req(if_req7), .if_addr(if_addr), .if_ack(if_ack7), .if_rdata(if_rdata7),
    .d_req(no_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack7), .d_rdata(d_rdata7),
    .mem_en(mem_en7), .mem_we(mem_we7), .mem_addr(mem_addr7), .mem_wdata(mem_wdata7),
    .mem_rdata(mem_rdata7), .busy(busy7));

  // Memory models: return the strobed address as data exactly L cycles after mem_en, junk otherwise.
  bit            pv0 [L0];
  bit            pv1 [L1];
  bit            pv7 [L7];
  logic [AW-1:0] pa0 [L0];
  logic [AW-1:0] pa1 [L1];
  logic [AW-1:0] pa7 [L7];

  always @(posedge clk) begin
    pv0[0] <= mem_en0; pa0[0] <= mem_addr0;
    for (int i = 1; i < L0; i++) begin pv0[i] <= pv0[i-1]; pa0[i] <= pa0[i-1]; end
    pv1[0] <= mem_en1; pa1[0] <= mem_addr1;
    for (int i = 1; i < L1; i++) begin pv1[i] <= pv1[i-1]; pa1[i] <= pa1[i-1]; end
    pv7[0] <= mem_en7; pa7[0] <= mem_addr7;
    for (int i = 1; i < L7; i++) begin pv7[i] <= pv7[i-1]; pa7[i] <= pa7[i-1]; end
  end

  assign mem_rdata0 = pv0[L0-1] ? {12'h0, pa0[L0-1]} : 32'hBAD0_BAD0;
  assign mem_rdata1 = pv1[L1-1] ? {12'h0, pa1[L1-1]} : 32'hBAD0_BAD0;
  assign mem_rdata7 = pv7[L7-1] ? {12'h0, pa7[L7-1]} : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input bit is_d, input logic [31:0] data, input int c);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    e.cyc  = c;
    return e;
  endfunction

  // Scoreboard consumers: every ack pops one expected entry; an ack with nothing pending fails.
  always @(negedge clk) begin
    exp_t e;
    if (if_ack0 || d_ack0) begin
      if (q0.size() == 0) chk("u0_spurious_ack", {d_ack0, if_ack0}, 2'b00);
      else begin
        e = q0.pop_front();
        chk("u0_ack_chan", {d_ack0, if_ack0}, e.is_d ? 2'b10 : 2'b01);
        chk("u0_rdata", e.is_d ? d_rdata0 : if_rdata0, e.data);
        chk("u0_ack_cycle", cyc, e.cyc);
      end
    end
    if (if_ack1 || d_ack1) begin
      if (q1.size() == 0) chk("u1_spurious_ack", {d_ack1, if_ack1}, 2'b00);
      else begin
        e = q1.pop_front();
        chk("u1_ack_chan", {d_ack1, if_ack1}, 2'b01);
        chk("u1_rdata", if_rdata1, e.data);
        chk("u1_ack_cycle", cyc, e.cyc);
      end
    end
    if (if_ack7 || d_ack7) begin
      if (q7.size() == 0) chk("u7_spurious_ack", {d_ack7, if_ack7}, 2'b00);
      else begin
        e = q7.pop_front();
        chk("u7_ack_chan", {d_ack7, if_ack7}, 2'b01);
        chk("u7_rdata", if_rdata7, e.data);
        chk("u7_ack_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic go_to(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    go_to(cyc + 2);
    rst = 1'b0;
  endtask

  initial begin
    int t0;
    int t1;
    int en_cnt;

    // Reset state
    do_reset();
    #3;
    chk("rst_busy", busy0, 1'b0);
    chk("rst_acks", {if_ack0, d_ack0}, 2'b00);
    chk("rst_mem_en", mem_en0, 1'b0);
    chk("rst_mem_we", mem_we0, 1'b0);
    chk("rst_mem_addr", mem_addr0, '0);
    chk("rst_mem_wdata", mem_wdata0, '0);
    chk("rst_if_rdata", if_rdata0, '0);
    chk("rst_d_rdata", d_rdata0, '0);

    // Single fetch on all three latencies
    go_to(cyc + 1);
    t0 = cyc;
    if_req = 1'b1; if_req1 = 1'b1; if_req7 = 1'b1; if_addr = 20'h00010;
    q0.push_back(mk(1'b0, 32'h10, t0 + 4));
    q1.push_back(mk(1'b0, 32'h10, t0 + 3));
    q7.push_back(mk(1'b0, 32'h10, t0 + 9));
    go_to(t0 + 1); #3;
    chk("fetch_mem_en", mem_en0, 1'b1);
    chk("fetch_mem_we", mem_we0, 1'b0);
    chk("fetch_mem_addr", mem_addr0, 20'h00010);
    chk("fetch_busy", busy0, 1'b1);
    chk("fetch_en_l1", mem_en1, 1'b1);
    chk("fetch_en_l7", mem_en7, 1'b1);
    go_to(t0 + 2); #3;
    chk("fetch_en_drop", mem_en0, 1'b0);
    go_to(t0 + 4); if_req1 = 1'b0;
    go_to(t0 + 5); if_req = 1'b0;
    go_to(t0 + 10); if_req7 = 1'b0;
    go_to(t0 + 12); #3;
    chk("fetch_q0_drained", q0.size(), 0);
    chk("fetch_q1_drained", q1.size(), 0);
    chk("fetch_q7_drained", q7.size(), 0);

    // Load on the data channel
    go_to(cyc + 1);
    t0 = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00200;
    q0.push_back(mk(1'b1, 32'h200, t0 + 4));
    go_to(t0 + 5); d_req = 1'b0;

    // Store: one-cycle write strobe, d_rdata keeps the previous load value
    go_to(t0 + 6);
    t0 = cyc;
    d_req = 1'b1; d_we = 1'b1; d_addr = 20'h00100; d_wdata = 32'h12345678;
    q0.push_back(mk(1'b1, 32'h200, t0 + 4));
    go_to(t0 + 1); #3;
    chk("store_mem_en", mem_en0, 1'b1);
    chk("store_mem_we", mem_we0, 1'b1);
    chk("store_mem_addr", mem_addr0, 20'h00100);
    chk("store_mem_wdata", mem_wdata0, 32'h12345678);
    go_to(t0 + 2); #3;
    chk("store_we_drop", mem_we0, 1'b0);
    chk("store_wdata_hold", mem_wdata0, 32'h12345678);
    go_to(t0 + 5); d_req = 1'b0; d_we = 1'b0;
    go_to(t0 + 7); #3;
    chk("if_rdata_hold", if_rdata0, 32'h10);
    chk("store_q0_drained", q0.size(), 0);

    // Tie after reset, both held: d, if, d, if
    do_reset();
    #3;
    chk("rst2_d_rdata", d_rdata0, '0);
    go_to(cyc + 1);
    t0 = cyc;
    if_req = 1'b1; if_addr = 20'h00030;
    d_req = 1'b1; d_addr = 20'h00040; d_we = 1'b0;
    q0.push_back(mk(1'b1, 32'h40, t0 + 4));
    q0.push_back(mk(1'b0, 32'h30, t0 + 9));
    q0.push_back(mk(1'b1, 32'h40, t0 + 14));
    q0.push_back(mk(1'b0, 32'h30, t0 + 19));
    go_to(t0 + 20); if_req = 1'b0; d_req = 1'b0;
    go_to(t0 + 22); #3;
    chk("tie_q0_drained", q0.size(), 0);

    // Reset during WAIT: no ack, idle next cycle, then data wins a fresh tie
    go_to(cyc + 1);
    t0 = cyc;
    if_req = 1'b1; if_addr = 20'h00050;
    go_to(t0 + 2); #3;
    chk("abort_busy_before", busy0, 1'b1);
    rst = 1'b1;
    go_to(t0 + 3);
    rst = 1'b0; if_req = 1'b0;
    #3;
    chk("abort_busy", busy0, 1'b0);
    chk("abort_mem_en", mem_en0, 1'b0);
    go_to(t0 + 4);
    t1 = cyc;
    if_req = 1'b1; if_addr = 20'h00058;
    d_req = 1'b1; d_addr = 20'h00068; d_we = 1'b0;
    q0.push_back(mk(1'b1, 32'h68, t1 + 4));
    q0.push_back(mk(1'b0, 32'h58, t1 + 9));
    go_to(t1 + 5); d_req = 1'b0;
    go_to(t1 + 10); if_req = 1'b0;
    go_to(t1 + 12); #3;
    chk("abort_q0_drained", q0.size(), 0);

    // Fetch request withdrawn before it could be granted
    go_to(cyc + 1);
    t0 = cyc;
    d_req = 1'b1; d_addr = 20'h00060; d_we = 1'b0;
    q0.push_back(mk(1'b1, 32'h60, t0 + 4));
    en_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      go_to(t0 + k);
      if (k == 2) begin if_req = 1'b1; if_addr = 20'h00070; end
      if (k == 3) if_req = 1'b0;
      if (k == 5) d_req = 1'b0;
      #3;
      if (mem_en0) en_cnt++;
      if (k == 1) chk("withdraw_mem_addr", mem_addr0, 20'h00060);
    end
    chk("withdraw_en_count", en_cnt, 1);
    chk("withdraw_busy", busy0, 1'b0);

    go_to(cyc + 3); #3;
    chk("final_q0_empty", q0.size(), 0);
    chk("final_q1_empty", q1.size(), 0);
    chk("final_q7_empty", q7.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
